// File: rtl/seg_arbiter_pkg.sv
// seg_arbiter_pkg: shared FSM state type and a width helper for the segment arbiter.
package seg_arbiter_pkg;

  // Arbiter FSM: IDLE accepts a segment, GAP enforces spacing between strobes.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } arb_state_e;

  // Width of a counter/index covering 0..value-1, never narrower than one bit.
  function automatic int safe_clog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/seg_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker. The search starts at
// ptr and wraps; the first valid requester found wins.
module rr_arbiter
  import seg_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = safe_clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_arbiter.sv
// seg_arbiter: round-robin arbiter feeding one line drawer with segments.
// Strobes are spaced by at least MIN_GAP cycles and at most MAX_PER_FRAME
// segments are issued per frame; excess grants are accepted and discarded.
// Optional feature macro: SEG_ARBITER_STATS_EN adds stat_issued/stat_dropped.
module seg_arbiter
  import seg_arbiter_pkg::*;
#(
  parameter int   NUM_REQ       = 4,
  parameter int   FRAME_HEIGHT  = -1,
  parameter int   FRAME_WIDTH   = -1,
  parameter int   MIN_GAP       = 16,
  parameter int   MAX_PER_FRAME = 1024,
  localparam int  V_BITW        = safe_clog2(FRAME_HEIGHT),
  localparam int  H_BITW        = safe_clog2(FRAME_WIDTH),
  localparam int  SRC_W         = safe_clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][V_BITW-1:0] req_start_v,
  input  logic [NUM_REQ-1:0][V_BITW-1:0] req_end_v,
  input  logic [NUM_REQ-1:0][H_BITW-1:0] req_start_h,
  input  logic [NUM_REQ-1:0][H_BITW-1:0] req_end_h,
  input  logic [V_BITW-1:0]              in_vcnt,
  input  logic [H_BITW-1:0]              in_hcnt,
  output logic                           out_en,
  output logic [V_BITW-1:0]              out_start_v,
  output logic [V_BITW-1:0]              out_end_v,
  output logic [H_BITW-1:0]              out_start_h,
  output logic [H_BITW-1:0]              out_end_h,
  output logic [SRC_W-1:0]               out_src
`ifdef SEG_ARBITER_STATS_EN
  ,
  output logic [31:0]                    stat_issued,
  output logic [31:0]                    stat_dropped
`endif
);

  localparam int CNT_W = $clog2(MAX_PER_FRAME + 1);
  localparam int GAP_W = safe_clog2(MIN_GAP);
  localparam int GAP_LOAD = (MIN_GAP > 1) ? MIN_GAP - 2 : 0;

  arb_state_e        state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  issued_cnt_q, issued_cnt_d;
  logic              out_en_q, out_en_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;
  logic [V_BITW-1:0] out_start_v_q, out_start_v_d;
  logic [V_BITW-1:0] out_end_v_q, out_end_v_d;
  logic [H_BITW-1:0] out_start_h_q, out_start_h_d;
  logic [H_BITW-1:0] out_end_h_q, out_end_h_d;

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_vld;
  logic               handshake;
  logic               budget_ok;
  logic               issue;
  logic               frame_end;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // A grant is only offered while idle and out of reset; the grant already
  // implies the chosen requester is valid, so a grant is a handshake.
  assign handshake = (state_q == IDLE) && !rst && grant_vld;
  assign req_ready = handshake ? grant : '0;
  assign budget_ok = issued_cnt_q < CNT_W'(MAX_PER_FRAME);
  assign issue     = handshake && budget_ok;
  assign frame_end = (in_vcnt == V_BITW'(FRAME_HEIGHT - 1)) &&
                     (in_hcnt == H_BITW'(FRAME_WIDTH - 1));

  // Next-state logic: pointer rotation, segment capture, gap timing, frame budget.
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    rr_ptr_d      = rr_ptr_q;
    issued_cnt_d  = issued_cnt_q;
    out_en_d      = 1'b0;
    out_src_d     = out_src_q;
    out_start_v_d = out_start_v_q;
    out_end_v_d   = out_end_v_q;
    out_start_h_d = out_start_h_q;
    out_end_h_d   = out_end_h_q;

    if (handshake) begin
      rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    if (issue) begin
      out_en_d      = 1'b1;
      out_src_d     = grant_idx;
      out_start_v_d = req_start_v[grant_idx];
      out_end_v_d   = req_end_v[grant_idx];
      out_start_h_d = req_start_h[grant_idx];
      out_end_h_d   = req_end_h[grant_idx];
    end

    // The strobe cycle itself is the first GAP cycle, so GAP spans MIN_GAP-1.
    case (state_q)
      IDLE: begin
        if (issue && (MIN_GAP > 1)) begin
          state_d   = GAP;
          gap_cnt_d = GAP_W'(GAP_LOAD);
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A segment issued on the last pixel of a frame counts toward the next frame.
    if (frame_end) begin
      issued_cnt_d = issue ? CNT_W'(1) : '0;
    end else if (issue && (issued_cnt_q != CNT_W'(MAX_PER_FRAME))) begin
      issued_cnt_d = issued_cnt_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      gap_cnt_q     <= '0;
      rr_ptr_q      <= '0;
      issued_cnt_q  <= '0;
      out_en_q      <= 1'b0;
      out_src_q     <= '0;
      out_start_v_q <= '0;
      out_end_v_q   <= '0;
      out_start_h_q <= '0;
      out_end_h_q   <= '0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      issued_cnt_q  <= issued_cnt_d;
      out_en_q      <= out_en_d;
      out_src_q     <= out_src_d;
      out_start_v_q <= out_start_v_d;
      out_end_v_q   <= out_end_v_d;
      out_start_h_q <= out_start_h_d;
      out_end_h_q   <= out_end_h_d;
    end
  end

  assign out_en      = out_en_q;
  assign out_src     = out_src_q;
  assign out_start_v = out_start_v_q;
  assign out_end_v   = out_end_v_q;
  assign out_start_h = out_start_h_q;
  assign out_end_h   = out_end_h_q;

`ifdef SEG_ARBITER_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_dropped_q, stat_dropped_d;
  logic        drop;

  assign drop = handshake && !budget_ok;

  // Saturating lifetime counters of issued and discarded segments.
  always_comb begin
    stat_issued_d  = stat_issued_q;
    stat_dropped_d = stat_dropped_q;
    if (issue && (stat_issued_q != '1)) begin
      stat_issued_d = stat_issued_q + 1'b1;
    end
    if (drop && (stat_dropped_q != '1)) begin
      stat_dropped_d = stat_dropped_q + 1'b1;
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      stat_issued_q  <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_issued_q  <= stat_issued_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: doc/seg_arbiter.md
SEG_ARBITER -- requirements
Module: seg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of segment requesters (2..8).
REQ-002 SHALL have parameter FRAME_HEIGHT, default -1: vertical frame size including sync.
REQ-003 SHALL have parameter FRAME_WIDTH, default -1: horizontal frame size including sync.
REQ-004 SHALL have parameter MIN_GAP, default 16: minimum cycles between consecutive out_en pulses (>=1).
REQ-005 SHALL have parameter MAX_PER_FRAME, default 1024: segments issued per frame before dropping.
REQ-006 SHALL use one clock and a synchronous, active-high reset. Localparams: V_BITW=$clog2(FRAME_HEIGHT), H_BITW=$clog2(FRAME_WIDTH).
REQ-007 SHALL have port clock  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst  in  1  synchronous active-high reset.
REQ-009 SHALL have port req_valid  in  NUM_REQ  per-requester segment valid.
REQ-010 SHALL have port req_ready  out  NUM_REQ  per-requester accept, combinational.
REQ-011 SHALL have ports req_start_v, req_end_v  in  NUM_REQ x V_BITW  per-requester vertical endpoints.
REQ-012 SHALL have ports req_start_h, req_end_h  in  NUM_REQ x H_BITW  per-requester horizontal endpoints.
REQ-013 SHALL have ports in_vcnt  in  V_BITW and in_hcnt  in  H_BITW  frame timing counters.
REQ-014 SHALL have port out_en  out  1  one-cycle segment strobe to the line drawer.
REQ-015 SHALL have ports out_start_v, out_end_v  out  V_BITW and out_start_h, out_end_h  out  H_BITW  issued segment.
REQ-016 SHALL have port out_src  out  $clog2(NUM_REQ)  index of the issuing requester.

Function
REQ-017 SHALL implement FSM states IDLE, GAP. Reset state: IDLE.
REQ-018 In IDLE with any req_valid, SHALL grant exactly one requester by round-robin. Search starts at rr_ptr. req_ready SHALL be high only for that requester, in the same cycle.
REQ-019 On a handshake, rr_ptr SHALL become (granted+1) mod NUM_REQ. It SHALL be unchanged otherwise.
REQ-020 On a handshake with budget remaining, SHALL register the segment and out_src, pulse out_en the next cycle (latency 1), and enter GAP.
REQ-021 GAP SHALL last MIN_GAP-1 cycles and then return to IDLE. req_ready SHALL be 0 throughout GAP. Result: out_en pulses are spaced at least MIN_GAP cycles apart.
REQ-022 With MIN_GAP==1, SHALL stay in IDLE. A grant SHALL then be possible every cycle.
REQ-023 When issued_cnt==MAX_PER_FRAME, SHALL still grant round-robin in IDLE (one per cycle) and discard the segment. No out_en, no GAP.
REQ-024 Frame boundary is (in_vcnt==FRAME_HEIGHT-1 && in_hcnt==FRAME_WIDTH-1). At the boundary, issued_cnt SHALL load 1 if an issue occurs the same cycle, else 0.
REQ-025 issued_cnt SHALL have width $clog2(MAX_PER_FRAME+1) and SHALL saturate at MAX_PER_FRAME.
REQ-026 Output data registers SHALL hold their last value while out_en is 0.
REQ-027 Requesters with req_valid low SHALL never receive req_ready.

Reset
REQ-028 On rst SHALL reset: state=IDLE, out_en=0, rr_ptr=0, issued_cnt=0, gap counter=0, out_src=0, all out coordinates=0. req_ready SHALL be 0 during rst.
REQ-029 rst asserted mid-GAP SHALL abort the gap. The first grant SHALL be possible in the cycle after rst deasserts.

Configuration
REQ-030 With macro SEG_ARBITER_STATS_EN defined, SHALL add outputs stat_issued (32 b) and stat_dropped (32 b). Both are saturating counters cleared only by rst, incremented per issued or discarded segment.
REQ-031 Without SEG_ARBITER_STATS_EN, these ports and counters SHALL not exist. All other behaviour SHALL be identical.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, GAP) in shared package seg_arbiter_pkg. Segment coordinate widths remain module localparams.
REQ-033 SHALL implement round-robin selection as one sub-module rr_arbiter: inputs request vector and pointer; outputs one-hot grant and index. rr_arbiter SHALL be purely combinational.

Verification
REQ-034 SHALL cover this scenario: NUM_REQ=4, MIN_GAP=16, all valid held high -> grants 0,1,2,3,0 and out_en at cycles 1,17,33,49,65 after release of rst.
REQ-035 SHALL cover this scenario: only req 2 valid, MIN_GAP=1 -> req_ready[2] high every cycle, out_src=2, out_en continuous.
REQ-036 SHALL cover this scenario: MAX_PER_FRAME=3, 5 segments queued before a frame boundary -> 3 out_en, 2 discarded (stat_dropped=2 with STATS_EN), next frame issues again.
REQ-037 SHALL cover this scenario: an issue coinciding with the frame boundary -> issued_cnt=1 afterwards, MAX_PER_FRAME-1 further issues allowed.
REQ-038 SHALL cover this scenario: rst pulsed 5 cycles into GAP -> out_en=0, rr_ptr=0, grant to req 0 in the first cycle after rst.
REQ-039 SHALL cover this scenario: segment (10,20)->(30,40) from req 1 -> out_start_v=10, out_start_h=20, out_end_v=30, out_end_h=40, out_src=1 with out_en.
